// File: rtl/int_controller.sv
// int_controller: four-source priority interrupt controller.
//
// The CPU sees it as a memory-mapped window of 7 byte registers starting at
// INTC_BASE:
//   +0 EN    rw   bit0 global enable, bits7:4 per-source masks (3..0)
//   +1 PEND  r/w1c bits3:0 pending flags
//   +2..+5 VEC0..VEC3  rw  ISR entry addresses
//   +6 STAT  ro   bit7 in_service, bits1:0 last dispatched source
//
// A rising edge on irq_src[i] sets PEND[i]. When globally enabled, idle and
// some unmasked source is pending, the lowest-index one is dispatched:
// a one-cycle int_req with int_vec = VECk. The block then waits for iret.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   irq_src[3:0]            peripheral interrupt lines (0 = highest priority)
//   iret                    one-cycle ISR-return pulse
//   mem_addr/w_data/w_en    CPU data-bus store port
//   mem_r_data              combinational register read data
//   int_req, int_vec        interrupt request pulse and ISR vector
//   int_en                  EN register contents
//
// Build option: define INTC_SYNC_EN to put irq_src through a two-flop
// synchronizer before edge detection (adds two cycles of latency).
module int_controller #(
  parameter logic [7:0] INTC_BASE = 8'hF0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] irq_src,
  input  logic       iret,
  input  logic [7:0] mem_addr,
  input  logic [7:0] mem_w_data,
  input  logic       mem_w_en,
  output logic [7:0] mem_r_data,
  output logic       int_req,
  output logic [7:0] int_en,
  output logic [7:0] int_vec
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      en;
  logic [3:0]      pend, pend_nxt;
  logic [3:0][7:0] vec;
  logic [1:0]      last;
  logic [3:0]      irq_in, irq_prev, rise, elig;
  logic [1:0]      sel;
  logic            dispatch, in_service;
  logic [8:0]      off;
  logic [2:0]      idx;
  logic            hit, wr, w1c;

`ifdef INTC_SYNC_EN
  // Synchronizer flops are deliberately not reset so they keep shifting
  // through reset and present a settled value at release.
  logic [3:0] sync1, sync2;
  always_ff @(posedge clock) begin
    sync1 <= irq_src;
    sync2 <= sync1;
  end
  assign irq_in = sync2;
`else
  assign irq_in = irq_src;
`endif

  // Sample register loads during reset too, so lines already high at
  // release do not look like fresh edges.
  always_ff @(posedge clock) irq_prev <= irq_in;
  assign rise = irq_in & ~irq_prev;

  // Window decode with a 9-bit difference: a borrow makes off large, so a
  // single compare covers both ends of the window even near 8'hFF.
  assign off = {1'b0, mem_addr} - {1'b0, INTC_BASE};
  assign hit = off < 9'd7;
  assign idx = off[2:0];
  assign wr  = mem_w_en & hit;
  assign w1c = wr & (idx == 3'd1);

  assign in_service = (state != IDLE);
  assign elig       = pend & en[7:4];
  assign dispatch   = (state == IDLE) & en[0] & (|elig);

  // Lowest eligible index wins: scan downward so the last hit is the lowest.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (elig[i]) sel = 2'(i);
  end

  // Per-source pending bit: a new edge beats both W1C and dispatch clears.
  for (genvar i = 0; i < 4; i++) begin : g_pend
    assign pend_nxt[i] = rise[i] |
                         (pend[i] & ~(w1c & mem_w_data[i]) &
                          ~(dispatch & (sel == 2'(i))));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dispatch) state_nxt = REQ;
      REQ:     state_nxt = SERVICE;
      SERVICE: if (iret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      en      <= '0;
      pend    <= '0;
      vec     <= '0;
      last    <= '0;
      int_req <= 1'b0;
      int_vec <= '0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      int_req <= dispatch;
      // Dispatch reads pre-write EN/VEC since both are sampled before the edge.
      if (dispatch) begin
        int_vec <= vec[sel];
        last    <= sel;
      end
      if (wr && idx == 3'd0) en <= mem_w_data;
      for (int i = 0; i < 4; i++)
        if (wr && idx == 3'(i + 2)) vec[i] <= mem_w_data;
    end
  end

  assign int_en = en;

  always_comb begin
    mem_r_data = 8'h00;
    if (hit) begin
      case (idx)
        3'd0:                   mem_r_data = en;
        3'd1:                   mem_r_data = {4'b0, pend};
        3'd2, 3'd3, 3'd4, 3'd5: mem_r_data = vec[2'(idx - 3'd2)];
        3'd6:                   mem_r_data = {in_service, 5'b0, last};
        default:                mem_r_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
module tb_int_controller;
  localparam logic [7:0] BASE = 8'hF0;
`ifdef INTC_SYNC_EN
  localparam int LAT  = 4;
  localparam bit SYNC = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit SYNC = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, iret, mem_w_en;
  logic [3:0] irq_src;
  logic [7:0] mem_addr, mem_w_data;
  logic [7:0] mem_r_data, int_en, int_vec;
  logic       int_req;

  int total = 0;
  int bad   = 0;

  int_controller #(.INTC_BASE(BASE)) dut (
    .clock(clock), .reset(reset), .irq_src(irq_src), .iret(iret),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
    .mem_r_data(mem_r_data), .int_req(int_req), .int_en(int_en),
    .int_vec(int_vec)
  );

  always #5 clock = ~clock;

  // Reference model: controller state as plain variables, advanced once per edge.
  logic [7:0] m_en, m_ivec;
  logic [7:0] m_vec [4];
  logic [3:0] m_pend, m_prev, m_d1, m_d2;
  logic [1:0] m_last;
  bit         m_insvc, m_req;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [7:0] a);
    int o = int'(a) - int'(BASE);
    if (o == 0) return m_en;
    if (o == 1) return {4'b0, m_pend};
    if (o >= 2 && o <= 5) return m_vec[o-2];
    if (o == 6) return {m_insvc, 5'b0, m_last};
    return 8'h00;
  endfunction

  task automatic model_edge();
    logic [3:0] cur, rise;
    bit disp;
    int k, w;
    cur  = SYNC ? m_d2 : irq_src;
    m_d2 = m_d1;
    m_d1 = irq_src;
    if (reset) begin
      m_en = 0; m_pend = 0; m_last = 0; m_insvc = 0; m_req = 0; m_ivec = 0;
      for (int i = 0; i < 4; i++) m_vec[i] = 0;
      m_prev = cur;
      return;
    end
    rise   = cur & ~m_prev;
    m_prev = cur;
    disp = 0; k = 0;
    if (m_en[0] && !m_insvc)
      for (int i = 3; i >= 0; i--)
        if (m_pend[i] && m_en[4+i]) begin disp = 1; k = i; end
    w = mem_w_en ? int'(mem_addr) - int'(BASE) : -1;
    if (w == 1) m_pend = m_pend & ~mem_w_data[3:0];
    if (disp) begin
      m_pend[k] = 1'b0;
      m_ivec    = m_vec[k];
      m_insvc   = 1;
      m_last    = 2'(k);
    end else if (iret && m_insvc && !m_req) m_insvc = 0;
    m_pend = m_pend | rise;
    m_req  = disp;
    if (w == 0) m_en = mem_w_data;
    if (w >= 2 && w <= 5) m_vec[w-2] = mem_w_data;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    mem_w_en = 0;
    iret     = 0;
    chk("int_req", {7'b0, int_req}, {7'b0, m_req});
    chk("int_vec", int_vec, m_ivec);
    chk("int_en", int_en, m_en);
    chk("rdata", mem_r_data, m_rd(mem_addr));
  endtask

  task automatic wr(input logic [7:0] o, input logic [7:0] d);
    mem_addr = BASE + o; mem_w_data = d; mem_w_en = 1;
    step();
  endtask

  task automatic rd(input logic [7:0] o, input logic [7:0] exp, input string tag);
    mem_addr = BASE + o;
    #1;
    chk(tag, mem_r_data, exp);
  endtask

  task automatic wait_req(input string tag, input int exp);
    int n = 0;
    do begin step(); n++; end while (int_req !== 1'b1 && n < 20);
    chk(tag, 8'(n), 8'(exp));
  endtask

  task automatic settle();
    irq_src = 0;
    repeat (LAT + 1) step();
  endtask

  initial begin
    logic seen;
    reset = 1; iret = 0; mem_w_en = 0; irq_src = 0; mem_addr = BASE; mem_w_data = 0;
    m_d1 = 0; m_d2 = 0; m_prev = 0;
    repeat (4) step();
    reset = 0;
    for (int o = 0; o < 7; o++) rd(8'(o), 8'h00, "reset_reg");
    chk("reset_req", {7'b0, int_req}, 8'h00);
    chk("reset_vec", int_vec, 8'h00);

    // Single source dispatch
    wr(0, 8'h11); wr(2, 8'h40);
    irq_src = 4'b0001;
    wait_req("t1_lat", LAT);
    chk("t1_vec", int_vec, 8'h40);
    rd(1, 8'h00, "t1_pend");
    rd(6, 8'h80, "t1_stat");
    step();
    chk("t1_pulse", {7'b0, int_req}, 8'h00);
    chk("t1_vec_hold", int_vec, 8'h40);
    iret = 1; step();
    settle();

    // Two simultaneous sources: priority then second after iret
    wr(0, 8'h31); wr(3, 8'h60);
    irq_src = 4'b0011;
    wait_req("t2_lat", LAT);
    chk("t2_vec0", int_vec, 8'h40);
    step();
    iret = 1; step();
    wait_req("t2_lat2", 1);
    chk("t2_vec1", int_vec, 8'h60);
    step(); iret = 1; step();
    settle();

    // Source 2 arrives while in service
    wr(4, 8'h77); wr(0, 8'h11);
    irq_src = 4'b0001;
    wait_req("t3_first", LAT);
    wr(0, 8'h41);
    irq_src = 4'b0101;
    seen = 0;
    repeat (LAT + 2) begin step(); seen |= int_req; end
    chk("t3_noreq", {7'b0, seen}, 8'h00);
    rd(1, 8'h04, "t3_pend");
    iret = 1; step();
    wait_req("t3_after_iret", 1);
    chk("t3_vec", int_vec, 8'h77);
    step(); iret = 1; step();
    settle();

    // Global disable holds pending; enable write triggers next edge
    wr(0, 8'h10);
    irq_src = 4'b0001;
    seen = 0;
    repeat (LAT + 2) begin step(); seen |= int_req; end
    chk("t4_noreq", {7'b0, seen}, 8'h00);
    rd(1, 8'h01, "t4_pend");
    wr(0, 8'h11);
    step();
    chk("t4_req", {7'b0, int_req}, 8'h01);
    chk("t4_vec", int_vec, 8'h40);
    step(); iret = 1; step();
    settle();
    wr(0, 8'h10);
    irq_src = 4'b0001;
    repeat (LAT + 1) step();
    settle();
    irq_src = 4'b0001;
    repeat (LAT - 2) step();
    wr(1, 8'h01);
    rd(1, 8'h01, "t4_set_wins");
    repeat (LAT) step();
    wr(1, 8'h01);
    rd(1, 8'h00, "t4_w1c");
    settle();

    // Reset during service with a held line
    wr(5, 8'hA5); wr(0, 8'h81);
    irq_src = 4'b1000;
    wait_req("t5_lat", LAT);
    chk("t5_vec", int_vec, 8'hA5);
    step();
    rd(6, 8'h83, "t5_stat");
    reset = 1;
    repeat (3) step();
    reset = 0;
    for (int o = 0; o < 7; o++) rd(8'(o), 8'h00, "t5_reg");
    chk("t5_en", int_en, 8'h00);
    chk("t5_vec0", int_vec, 8'h00);
    seen = 0;
    repeat (LAT + 2) begin step(); seen |= int_req; end
    iret = 1; step();
    rd(6, 8'h00, "t5_iret_ignored");
    wr(0, 8'h81);
    repeat (LAT + 1) begin step(); seen |= int_req; end
    chk("t5_noreq", {7'b0, seen}, 8'h00);
    settle();

    // Out-of-window read, read-only STAT
    rd(7, 8'h00, "t6_oob");
    mem_addr = 8'h10; #1;
    chk("t6_low", mem_r_data, 8'h00);
    wr(6, 8'hFF);
    rd(6, 8'h00, "t6_stat_ro");

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      irq_src = 4'($urandom);
      if ($urandom % 3 == 0) begin
        mem_addr   = BASE + 8'($urandom % 8);
        mem_w_data = 8'($urandom);
        mem_w_en   = 1;
      end else begin
        mem_addr = ($urandom % 4 == 0) ? 8'($urandom) : BASE + 8'($urandom % 8);
      end
      iret = ($urandom % 4 == 0) && !m_req;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
